mul_sequencer: RTL and testbench
================================

# mul_sequencer

Iterative shift-add multiplier sequencer for the execute stage. It takes two N-bit operands on a start request and runs one partial product per clock for N cycles. While it runs, it holds the pipeline with a stall output, then presents the low N bits of the product for one done cycle. It sits beside the execute-stage ALU and serves MUL-class instructions that the single-cycle ALU cannot complete.

## Interface
- N, 64, operand, product and iteration-count width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request a multiply; sampled only in IDLE
- cancel  in  1  abort an in-progress multiply (pipeline flush)
- a  in  N  multiplicand, sampled with start
- b  in  N  multiplier, sampled with start
- stall  out  1  hold fetch/decode/execute registers
- busy  out  1  high in RUN state
- done  out  1  one-cycle pulse: product valid and new
- product  out  N  low N bits of a*b; registered, held until the next completion

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Internal registers:
  - mcand (N bits)
  - mplier (N bits)
  - acc (N bits)
  - cnt ($clog2(N)+1 bits)
- IDLE:
  - If start=1 and cancel=0 at the edge: mcand<=a, mplier<=b, acc<=0, cnt<=0, go to RUN.
  - If start=1 and cancel=1: stay in IDLE, nothing loaded.
- RUN, each edge:
  - If mplier[0]=1, then acc <= acc + mcand (mod 2^N).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
  - When cnt = N-1 at the edge, this is the last iteration: go to DONE and load product with the final acc value, including this iteration's add.
- DONE: lasts exactly one cycle, then goes to IDLE unconditionally. start is ignored in DONE.
- cancel in RUN: go to IDLE at the next edge; product and done are unchanged (done stays 0). cancel has no effect in DONE.
- Arithmetic: modulo 2^N; no overflow flag. The low N bits are identical for signed and unsigned operands, so there is no sign-handling logic.
- Outputs:
  - stall = (state==RUN) | (state==IDLE & start & ~cancel), combinational, so the requesting instruction freezes in the same cycle it presents start.
  - busy = (state==RUN).
  - done = (state==DONE), registered state decode.
  - product is a register, written only on the RUN→DONE transition.
- Reset values: state IDLE; product 0; done 0; busy 0; stall 0 when start=0; acc/mcand/mplier/cnt 0.

## Timing
- Start accepted at edge E0. RUN occupies the cycles after E0 through E_N, giving N iterations.
- The DONE cycle follows E_N. done=1, stall=0 and product is valid in that cycle; total latency is N+1 cycles from the start edge.
- stall is high from the start cycle through the last RUN cycle, N+1 cycles in total, and low during DONE so the stalled instruction advances with the result.
- A new start is accepted in the first IDLE cycle after DONE, giving back-to-back throughput of one multiply per N+2 cycles.
- Asserting reset at any point, including mid-RUN or during DONE, forces IDLE with outputs at reset values immediately. A pending multiply is lost, and no done is produced for it after reset deasserts.
- cancel and the final iteration in the same cycle: cancel wins. The state goes to IDLE, product is not written and done is not pulsed.

## Test plan
- a=3, b=5 (N=64), start pulse:
  - stall high for 65 cycles, busy high for 64.
  - done pulses on cycle 65 after the start edge with product=15.
  - product holds 15 afterwards.
- a=-2 (0xFFFF_FFFF_FFFF_FFFE), b=7 → product=0xFFFF_FFFF_FFFF_FFF2.
- a=b=0xFFFF_FFFF_FFFF_FFFF → product=1.
- a=0, b=0x8000_0000_0000_0000 → product=0; full 64 iterations still occur (done at cycle 65).
- Start 6×7, assert cancel at RUN iteration 10:
  - IDLE on the next edge, no done pulse, product keeps its prior value.
  - Then start 2×9 → done with product=18.
- Start a multiply, assert reset asynchronously mid-RUN (between clock edges):
  - state/outputs clear without waiting for an edge; product=0, busy=0.
  - After release, no done pulse; a fresh start 4×4 yields 16.
- Back-to-back: hold start high continuously with a=2, b=3 → done pulses every 66 cycles (N+2), each with product 6.
  - start is ignored during DONE; the next multiply loads on the IDLE cycle that follows.

Source files
------------

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for MUL-class instructions in the execute stage.
// One partial product per clock; stalls the pipeline and then pulses done with the low N bits of a*b.
module mul_sequencer #(
    parameter int unsigned N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         cancel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_mplier;
    logic [N-1:0]   r_acc;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_product;

    state_t         w_state_nxt;
    logic [N-1:0]   w_mcand_nxt;
    logic [N-1:0]   w_mplier_nxt;
    logic [N-1:0]   w_acc_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [N-1:0]   w_product_nxt;
    logic [N-1:0]   w_sum;
    logic           w_last;
    logic           w_accept;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mcand   <= w_mcand_nxt;
            r_mplier  <= w_mplier_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
        end
    end

    // Next-state and datapath update; product is written only on the final uncancelled iteration.
    always_comb begin
        w_state_nxt   = r_state;
        w_mcand_nxt   = r_mcand;
        w_mplier_nxt  = r_mplier;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_sum         = r_acc + (r_mplier[0] ? r_mcand : {N{1'b0}});
        w_last        = (r_cnt == CW'(N - 1));
        w_accept      = start & ~cancel;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mcand_nxt  = a;
                    w_mplier_nxt = b;
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_RUN;
                end
            end
            S_RUN: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_acc_nxt    = w_sum;
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt + CW'(1);
                    if (w_last) begin
                        w_product_nxt = w_sum;
                        w_state_nxt   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // stall is combinational so the requesting instruction freezes in its own start cycle.
    assign stall   = (r_state == S_RUN) | ((r_state == S_IDLE) & start & ~cancel);
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: job-level reference model compared every cycle,
// plus directed multiplies with literal products and latency counts.
module tb_mul_sequencer;

    localparam int unsigned N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cancel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         stall;
    logic         busy;
    logic         done;
    logic [N-1:0] product;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    mul_sequencer #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cancel  (cancel),
        .a       (a),
        .b       (b),
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model at job level: a job accepted at an edge finishes N edges later,
    // then one result cycle, during which new requests are ignored.
    bit           m_run;
    bit           m_done;
    int           m_left;
    logic [N-1:0] m_job;
    logic [N-1:0] m_prod;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run  = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            m_prod = '0;
            m_job  = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_run) begin
            if (cancel) begin
                m_run = 1'b0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_prod = m_job;
                end
            end
        end else if (start && !cancel) begin
            m_run  = 1'b1;
            m_left = N;
            m_job  = a * b;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        cyc++;
        #2;
        chk("model_busy",    N'(busy),  N'(m_run));
        chk("model_done",    N'(done),  N'(m_done));
        chk("model_stall",   N'(stall), N'(m_run | (!m_run & !m_done & start & !cancel)));
        chk("model_product", product,   m_prod);
        if (done) done_cnt++;
    end

    // Directed multiply with full-latency expectations.
    task automatic run_mul(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic [N-1:0] exp_p);
        int  edges;
        int  stall_cnt;
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        #1;
        stall_cnt = stall ? 1 : 0;
        busy_cnt  = 0;
        @(posedge clk);
        #2;
        if (stall) stall_cnt++;
        if (busy)  busy_cnt++;
        start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            edges++;
            #2;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (stall) stall_cnt++;
                if (busy)  busy_cnt++;
            end
        end
        chk("done_seen",      N'(seen),      N'(1));
        chk("done_edge",      N'(edges),     N'(64));
        chk("stall_cycles",   N'(stall_cnt), N'(65));
        chk("busy_cycles",    N'(busy_cnt),  N'(64));
        chk("done_product",   product,       exp_p);
        chk("done_stall_low", N'(stall),     N'(0));
        @(posedge clk);
        #2;
        chk("product_hold",   product,       exp_p);
        chk("done_one_cycle", N'(done),      N'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int got;
        int prev_cyc;
        logic [N-1:0] w;

        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_product", product,  '0);
        chk("reset_busy",    N'(busy), N'(0));
        chk("reset_done",    N'(done), N'(0));
        chk("reset_stall",   N'(stall), N'(0));
        @(negedge clk);
        reset = 1'b0;

        run_mul(64'd3, 64'd5, 64'd15);
        run_mul(64'hFFFF_FFFF_FFFF_FFFE, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        run_mul(64'h0, 64'h8000_0000_0000_0000, 64'd0);
        run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);

        // Cancel mid-run: no done, product keeps 1 from the previous job.
        @(negedge clk);
        start = 1'b1;
        a     = 64'd6;
        b     = 64'd7;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #2;
        cancel = 1'b0;
        chk("cancel_busy",    N'(busy), N'(0));
        chk("cancel_done",    N'(done), N'(0));
        chk("cancel_product", product,  64'd1);
        d0 = done_cnt;
        repeat (80) @(posedge clk);
        #3;
        chk("cancel_no_done", N'(done_cnt - d0), N'(0));
        chk("cancel_product_kept", product, 64'd1);
        run_mul(64'd2, 64'd9, 64'd18);

        // Asynchronous reset mid-run.
        @(negedge clk);
        start = 1'b1;
        a     = 64'd5;
        b     = 64'd5;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_product", product,   '0);
        chk("areset_busy",    N'(busy),  N'(0));
        chk("areset_done",    N'(done),  N'(0));
        chk("areset_stall",   N'(stall), N'(0));
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (80) @(posedge clk);
        #3;
        chk("areset_no_done", N'(done_cnt - d0), N'(0));
        run_mul(64'd4, 64'd4, 64'd16);

        // Back-to-back with start held high.
        @(negedge clk);
        start    = 1'b1;
        a        = 64'd2;
        b        = 64'd3;
        prev_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            got = 0;
            for (int t = 0; t < 300 && got == 0; t++) begin
                @(posedge clk);
                #2;
                if (done) got = 1;
            end
            chk("b2b_done_seen", N'(got), N'(1));
            chk("b2b_product",   product, 64'd6);
            if (k > 0) chk("b2b_period", N'(cyc - prev_cyc), N'(66));
            prev_cyc = cyc;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(posedge clk);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start  = ($urandom_range(3) != 0);
            cancel = ($urandom_range(255) == 0);
            w      = {$urandom, $urandom};
            a      = ($urandom_range(7) == 0) ? {N{1'b1}} : w;
            b      = {$urandom, $urandom};
            if ($urandom_range(7) == 0) b = b & 64'hFF;
        end
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        repeat (70) @(posedge clk);
        #3;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
